// File: rtl/pad_share_arbiter.sv
// pad_share_arbiter: round-robin owner of a shared pad bank for
// three requesters (0 SPI ss, 1 PWM, 2 GPIO), with bus turnaround.
//
// Ports:
//   clk_i, rst_i      clock, synchronous active-high reset
//   req_i[2:0]        ownership request per requester
//   out_i, oe_i       requester pad data / output enable,
//                     slice [r*NPINS +: NPINS] is requester r
//   gnt_o[2:0]        registered one-hot (or zero) grant
//   pad_out_o         data to the pads
//   pad_oeb_o         pad output enable, active-low
//   busy_o            high in GRANT or TURN
//   revoke_o          one-cycle pulse after a forced MAX_HOLD revoke
module pad_share_arbiter #(
  parameter int NPINS    = 4,
  parameter int TURN_CYC = 2,
  parameter int MAX_HOLD = 0
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [2:0]           req_i,
  input  logic [3*NPINS-1:0]   out_i,
  input  logic [3*NPINS-1:0]   oe_i,
  output logic [2:0]           gnt_o,
  output logic [NPINS-1:0]     pad_out_o,
  output logic [NPINS-1:0]     pad_oeb_o,
  output logic                 busy_o,
  output logic                 revoke_o
);

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    TURN
  } state_t;

  localparam logic [16:0] HOLD_LIM = 17'(MAX_HOLD);

  state_t      state_q, state_d;
  logic [2:0]  gnt_d;
  logic [1:0]  owner_q, owner_d;
  logic [1:0]  last_q, last_d;
  logic [15:0] hold_q, hold_d;
  logic [3:0]  turn_q, turn_d;
  logic        revoke_d;
  logic        hold_hit;
  logic        other_pend;

  // Earliest hit in the order last+1, last+2, last+3 (mod 3).
  // Scanning from the far end lets the nearest hit overwrite.
  function automatic logic [1:0] rr_pick(
    input logic [1:0] last,
    input logic [2:0] req
  );
    logic [1:0] pick;
    int         s;
    pick = 2'd0;
    for (int i = 3; i >= 1; i--) begin
      s = (int'(last) + i) % 3;
      if (req[s]) pick = 2'(s);
    end
    return pick;
  endfunction

  // hold_q counts completed grant cycles, so the cycle that
  // completes the MAX_HOLD-th one is the last one allowed.
  assign hold_hit = (MAX_HOLD != 0) &&
                    (({1'b0, hold_q} + 17'd1) >= HOLD_LIM);

  assign other_pend = |(req_i & ~gnt_o);

  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_o;
    owner_d  = owner_q;
    last_d   = last_q;
    hold_d   = hold_q;
    turn_d   = turn_q;
    revoke_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (|req_i) begin
          owner_d = rr_pick(last_q, req_i);
          gnt_d   = 3'b001 << owner_d;
          hold_d  = '0;
          state_d = GRANT;
        end
      end
      GRANT: begin
        if (!req_i[owner_q] ||
            (hold_hit && other_pend)) begin
          gnt_d    = '0;
          last_d   = owner_q;
          // only a still-requesting owner is forcibly revoked
          revoke_d = req_i[owner_q];
          turn_d   = 4'(TURN_CYC);
          state_d  = (TURN_CYC == 0) ? IDLE : TURN;
        end else if (hold_q != 16'hFFFF) begin
          hold_d = hold_q + 16'd1;
        end
      end
      TURN: begin
        if (turn_q <= 4'd1) begin
          turn_d  = '0;
          state_d = IDLE;
        end else begin
          turn_d = turn_q - 4'd1;
        end
      end
      default: begin
        gnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      gnt_o    <= '0;
      owner_q  <= '0;
      last_q   <= 2'd2;
      hold_q   <= '0;
      turn_q   <= '0;
      revoke_o <= 1'b0;
    end else begin
      state_q  <= state_d;
      gnt_o    <= gnt_d;
      owner_q  <= owner_d;
      last_q   <= last_d;
      hold_q   <= hold_d;
      turn_q   <= turn_d;
      revoke_o <= revoke_d;
    end
  end

  assign busy_o = (state_q != IDLE);

  // Pads stay tri-stated while reset is held, even before the
  // first reset edge has cleared the grant register.
  always_comb begin
    pad_out_o = '0;
    pad_oeb_o = '1;
    if (!rst_i) begin
      unique case (1'b1)
        gnt_o[0]: begin
          pad_out_o = out_i[0 +: NPINS];
          pad_oeb_o = ~oe_i[0 +: NPINS];
        end
        gnt_o[1]: begin
          pad_out_o = out_i[NPINS +: NPINS];
          pad_oeb_o = ~oe_i[NPINS +: NPINS];
        end
        gnt_o[2]: begin
          pad_out_o = out_i[2*NPINS +: NPINS];
          pad_oeb_o = ~oe_i[2*NPINS +: NPINS];
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pad_share_arbiter.sv
// tb_pad_share_arbiter: directed vectors and corner sequences
// for pad_share_arbiter at three parameter sets.
module tb_pad_share_arbiter;

  logic        clk;
  logic        rst;
  logic [2:0]  req_a, req_b, req_c;
  logic [11:0] out_v, oe_v;

  logic [2:0]  gnt_a, gnt_b, gnt_c;
  logic [3:0]  pout_a, pout_b, pout_c;
  logic [3:0]  poeb_a, poeb_b, poeb_c;
  logic        busy_a, busy_b, busy_c;
  logic        rev_a, rev_b, rev_c;

  int checks = 0;
  int errors = 0;

  // slices: r0 A/oe F, r1 5/oe 6, r2 3/oe 9
  assign out_v = 12'h35A;
  assign oe_v  = 12'h96F;

  pad_share_arbiter #(
    .NPINS(4), .TURN_CYC(2), .MAX_HOLD(0)
  ) dut_a (
    .clk_i(clk), .rst_i(rst), .req_i(req_a),
    .out_i(out_v), .oe_i(oe_v), .gnt_o(gnt_a),
    .pad_out_o(pout_a), .pad_oeb_o(poeb_a),
    .busy_o(busy_a), .revoke_o(rev_a)
  );

  pad_share_arbiter #(
    .NPINS(4), .TURN_CYC(2), .MAX_HOLD(8)
  ) dut_b (
    .clk_i(clk), .rst_i(rst), .req_i(req_b),
    .out_i(out_v), .oe_i(oe_v), .gnt_o(gnt_b),
    .pad_out_o(pout_b), .pad_oeb_o(poeb_b),
    .busy_o(busy_b), .revoke_o(rev_b)
  );

  pad_share_arbiter #(
    .NPINS(4), .TURN_CYC(0), .MAX_HOLD(0)
  ) dut_c (
    .clk_i(clk), .rst_i(rst), .req_i(req_c),
    .out_i(out_v), .oe_i(oe_v), .gnt_o(gnt_c),
    .pad_out_o(pout_c), .pad_oeb_o(poeb_c),
    .busy_o(busy_c), .revoke_o(rev_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       rst;
    logic [2:0] req;
    logic [2:0] gnt;
    logic       busy;
    logic       rev;
    logic [7:0] pad;
  } vec_t;

  localparam logic [7:0] PZ = 8'h0F;
  localparam logic [7:0] P0 = 8'hA0;
  localparam logic [7:0] P1 = 8'h59;
  localparam logic [7:0] P2 = 8'h36;

  vec_t tbl [25];

  task automatic chk(
    input string       name,
    input logic [15:0] act,
    input logic [15:0] exp
  );
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  task automatic step(
    input logic       r,
    input logic [2:0] a,
    input logic [2:0] b,
    input logic [2:0] c
  );
    rst   = r;
    req_a = a;
    req_b = b;
    req_c = c;
    @(posedge clk);
    #1;
  endtask

  logic [2:0] own, rq, eg;
  int         k, p;
  logic       er;

  initial begin
    tbl[0]  = '{1'b1, 3'b000, 3'b000, 1'b0, 1'b0, PZ};
    tbl[1]  = '{1'b0, 3'b010, 3'b010, 1'b1, 1'b0, P1};
    tbl[2]  = '{1'b0, 3'b010, 3'b010, 1'b1, 1'b0, P1};
    tbl[3]  = '{1'b0, 3'b000, 3'b000, 1'b1, 1'b0, PZ};
    tbl[4]  = '{1'b0, 3'b000, 3'b000, 1'b1, 1'b0, PZ};
    tbl[5]  = '{1'b0, 3'b000, 3'b000, 1'b0, 1'b0, PZ};
    tbl[6]  = '{1'b0, 3'b111, 3'b100, 1'b1, 1'b0, P2};
    tbl[7]  = '{1'b0, 3'b011, 3'b000, 1'b1, 1'b0, PZ};
    tbl[8]  = '{1'b0, 3'b011, 3'b000, 1'b1, 1'b0, PZ};
    tbl[9]  = '{1'b0, 3'b011, 3'b000, 1'b0, 1'b0, PZ};
    tbl[10] = '{1'b0, 3'b011, 3'b001, 1'b1, 1'b0, P0};
    tbl[11] = '{1'b0, 3'b011, 3'b001, 1'b1, 1'b0, P0};
    tbl[12] = '{1'b1, 3'b011, 3'b000, 1'b0, 1'b0, PZ};
    tbl[13] = '{1'b0, 3'b011, 3'b001, 1'b1, 1'b0, P0};
    tbl[14] = '{1'b0, 3'b010, 3'b000, 1'b1, 1'b0, PZ};
    tbl[15] = '{1'b0, 3'b000, 3'b000, 1'b1, 1'b0, PZ};
    tbl[16] = '{1'b0, 3'b100, 3'b000, 1'b0, 1'b0, PZ};
    tbl[17] = '{1'b0, 3'b100, 3'b100, 1'b1, 1'b0, P2};
    tbl[18] = '{1'b0, 3'b000, 3'b000, 1'b1, 1'b0, PZ};
    tbl[19] = '{1'b1, 3'b000, 3'b000, 1'b0, 1'b0, PZ};
    tbl[20] = '{1'b0, 3'b000, 3'b000, 1'b0, 1'b0, PZ};
    tbl[21] = '{1'b0, 3'b010, 3'b010, 1'b1, 1'b0, P1};
    tbl[22] = '{1'b1, 3'b011, 3'b000, 1'b0, 1'b0, PZ};
    tbl[23] = '{1'b0, 3'b011, 3'b001, 1'b1, 1'b0, P0};
    tbl[24] = '{1'b0, 3'b000, 3'b000, 1'b1, 1'b0, PZ};

    rst   = 1'b1;
    req_a = '0;
    req_b = '0;
    req_c = '0;
    step(1'b1, 3'b000, 3'b000, 3'b000);
    step(1'b1, 3'b000, 3'b000, 3'b000);

    chk("reset_bc",
        {gnt_b, gnt_c, busy_b, busy_c, rev_b, rev_c, 6'd0},
        16'h0000);
    chk("reset_pads_bc",
        {pout_b, poeb_b, pout_c, poeb_c},
        16'h0F0F);

    // table: default parameters on dut_a
    for (int i = 0; i < 25; i++) begin
      step(tbl[i].rst, tbl[i].req, 3'b000, 3'b000);
      chk($sformatf("vec%0d", i),
          {3'b000, gnt_a, busy_a, rev_a, pout_a, poeb_a},
          {3'b000, tbl[i].gnt, tbl[i].busy, tbl[i].rev,
           tbl[i].pad});
    end

    // round robin, all requesting, each owner drops once
    step(1'b1, 3'b000, 3'b000, 3'b000);
    for (int c = 0; c < 29; c++) begin
      k   = c / 8;
      p   = c % 8;
      own = 3'(1 << (k % 3));
      rq  = (p == 5) ? (3'b111 & ~own) : 3'b111;
      eg  = (p < 5) ? own : 3'b000;
      step(1'b0, rq, 3'b000, 3'b000);
      chk($sformatf("rr_c%0d", c),
          {12'd0, gnt_a, busy_a},
          {12'd0, eg, (p != 7)});
    end

    // MAX_HOLD timeout with a competitor arriving mid-grant
    step(1'b1, 3'b000, 3'b000, 3'b000);
    for (int c = 0; c < 13; c++) begin
      rq = (c >= 3) ? 3'b101 : 3'b001;
      if (c <= 7)       eg = 3'b001;
      else if (c <= 10) eg = 3'b000;
      else              eg = 3'b100;
      er = (c == 8);
      step(1'b0, 3'b000, rq, 3'b000);
      chk($sformatf("hold_c%0d", c),
          {12'd0, gnt_b, rev_b},
          {12'd0, eg, er});
    end

    // MAX_HOLD expiry with no competitor keeps the grant
    step(1'b1, 3'b000, 3'b000, 3'b000);
    for (int c = 0; c < 20; c++) begin
      step(1'b0, 3'b000, 3'b010, 3'b000);
      chk($sformatf("solo_c%0d", c),
          {11'd0, gnt_b, busy_b, rev_b},
          {11'd0, 3'b010, 1'b1, 1'b0});
    end

    // zero turnaround: a single idle cycle between owners
    step(1'b1, 3'b000, 3'b000, 3'b000);
    step(1'b0, 3'b000, 3'b000, 3'b001);
    chk("t0_g0", {12'd0, gnt_c, busy_c}, {12'd0, 3'b001, 1'b1});
    step(1'b0, 3'b000, 3'b000, 3'b001);
    chk("t0_g0b", {12'd0, gnt_c, rev_c}, {12'd0, 3'b001, 1'b0});
    step(1'b0, 3'b000, 3'b000, 3'b010);
    chk("t0_gap", {4'd0, gnt_c, busy_c, pout_c, poeb_c},
        {4'd0, 3'b000, 1'b0, PZ});
    step(1'b0, 3'b000, 3'b000, 3'b010);
    chk("t0_g1", {4'd0, gnt_c, busy_c, pout_c, poeb_c},
        {4'd0, 3'b010, 1'b1, P1});
    step(1'b0, 3'b000, 3'b000, 3'b010);
    chk("t0_g1b", {12'd0, gnt_c, busy_c}, {12'd0, 3'b010, 1'b1});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
